// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pulse_stretcher_pkg;

  // FSM encoding, kept as plain 2-bit constants.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HIGH = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  // Larger of two integers; used to size the shared high/gap timer.
  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter for queued events. Simultaneous inc/dec leaves
// the count unchanged; an inc that finds the counter full with no dec is
// reported as a drop.
module pend_counter #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         drop
);

  logic [W-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == W'(MAX));
  assign drop  = inc && !dec && full && !clr;
  assign count = cnt_q;

  // Next count: flush wins, otherwise saturating step; never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Turns one-cycle event strobes into fixed-length high periods, each followed
// by a forced low gap. Optional queueing of events that arrive while busy is
// enabled with PULSE_STRETCHER_QUEUE_EN; without it such events are dropped
// (flagging overflow), except one landing on the gap exit cycle.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_MAX    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pulse_in,
  input  logic                          clear,
  output logic                          level_out,
  output logic                          busy,
  output logic [$clog2(PEND_MAX+1)-1:0] pending,
  output logic                          overflow
);

  localparam int TW = $clog2(max(HIGH_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(max(GAP_CYCLES, 1) - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          level_q, level_d;
  logic          busy_q,  busy_d;
  logic          ovf_q,   ovf_d;

  logic active;    // in HIGH or GAP
  logic exit_now;  // current period sequence ends this cycle
  logic avail;     // an event is ready to start on exit
  logic consume;   // exit restarts HIGH using an event
  logic drop;      // event discarded this cycle

  assign active = (state_q != ST_IDLE);

`ifdef PULSE_STRETCHER_QUEUE_EN
  localparam int PW = $clog2(PEND_MAX + 1);
  logic q_inc, q_full, q_drop;

  assign q_inc = active && pulse_in && !clear;
  assign avail = (pending != '0) || pulse_in;
  // A drop strobe can only occur with the queue full.
  assign drop  = q_drop && q_full;

  pend_counter #(.MAX(PEND_MAX), .W(PW)) u_pend (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (q_inc),
    .dec   (consume),
    .count (pending),
    .full  (q_full),
    .drop  (q_drop)
  );
`else
  assign pending = '0;
  assign avail   = pulse_in;
  // Busy-time events are lost unless they land exactly on the exit cycle.
  assign drop    = active && pulse_in && !exit_now && !clear;
`endif

  // FSM and timer next-state; clear overrides everything.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    exit_now = 1'b0;
    consume  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pulse_in) begin
          state_d = ST_HIGH;
          timer_d = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          timer_d = GAP_LOAD;
        end else begin
          exit_now = 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        else               exit_now = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    if (exit_now) begin
      if (avail) begin
        state_d = ST_HIGH;
        timer_d = HIGH_LOAD;
        consume = 1'b1;
      end else begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    end
    if (clear) begin
      state_d = ST_IDLE;
      timer_d = '0;
      consume = 1'b0;
    end
  end

  // Registered outputs derived from the next state so they move together.
  always_comb begin
    level_d = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
    ovf_d   = clear ? 1'b0 : (ovf_q || drop);
  end

  // State, timer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher (HIGH=4, GAP=2, PEND_MAX=3). A cycle
// model of the block pushes expected outputs when stimulus is driven; they
// are popped and compared after the clock edge. Directed checks cover the
// timing cases with fixed expected values.
module tb_pulse_stretcher;

  localparam int HC = 4;
  localparam int GC = 2;
  localparam int PM = 3;
  localparam int PW = $clog2(PM + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pulse_in = 1'b0;
  logic          clear = 1'b0;
  logic          level_out, busy, overflow;
  logic [PW-1:0] pending;

  typedef struct packed {
    logic       lvl;
    logic       bsy;
    logic       ovf;
    logic [7:0] pnd;
  } exp_t;

  exp_t sb_q[$];

  int n_chk = 0;
  int n_err = 0;
  int m_state, m_timer, m_pend, m_ovf;
  int rises, hi_cyc;
  logic prev_lvl = 1'b0;

  pulse_stretcher #(.HIGH_CYCLES(HC), .GAP_CYCLES(GC), .PEND_MAX(PM)) dut (
    .clk       (clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .clear     (clear),
    .level_out (level_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_timer = 0; m_pend = 0; m_ovf = 0;
  endtask

  // Reference behaviour for one clock with inputs p (pulse) and c (clear).
  task automatic m_step(input logic p, input logic c);
    bit act, ex, av;
    act = (m_state != 0);
    ex  = 0;
    if (c) begin
      m_reset();
      return;
    end
    case (m_state)
      0: if (p) begin m_state = 1; m_timer = HC - 1; end
      1: if (m_timer > 0) m_timer--;
         else if (GC > 0) begin m_state = 2; m_timer = GC - 1; end
         else ex = 1;
      default: if (m_timer > 0) m_timer--; else ex = 1;
    endcase
`ifdef PULSE_STRETCHER_QUEUE_EN
    av = (m_pend + int'(p)) > 0;
    if (act && p && !(ex && av)) begin
      if (m_pend == PM) m_ovf = 1;
      else              m_pend++;
    end else if (!(act && p) && ex && av) begin
      m_pend--;
    end
`else
    av = p;
    if (act && p && !ex) m_ovf = 1;
`endif
    if (ex) begin
      if (av) begin m_state = 1; m_timer = HC - 1; end
      else    begin m_state = 0; m_timer = 0; end
    end
  endtask

  // Drive one cycle: push model expectation, clock, pop and compare.
  task automatic cyc(input logic p, input logic c);
    exp_t e, g;
    pulse_in = p;
    clear    = c;
    m_step(p, c);
    e.lvl = (m_state == 1);
    e.bsy = (m_state != 0);
    e.ovf = m_ovf[0];
    e.pnd = 8'(m_pend);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
    clear    = 1'b0;
    e = sb_q.pop_front();
    g.lvl = level_out;
    g.bsy = busy;
    g.ovf = overflow;
    g.pnd = 8'(pending);
    chk("sb", 32'(g), 32'(e));
    if (level_out && !prev_lvl) rises++;
    if (level_out) hi_cyc++;
    prev_lvl = level_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lvl", 32'(level_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_ovf", 32'(overflow), 0);
    #2 reset = 1'b1;
    idle(3);

    // Single pulse: 4 high, busy through the gap, idle afterwards.
    rises = 0; hi_cyc = 0;
    cyc(1'b1, 1'b0);
    chk("single_lat", 32'(level_out), 1);
    idle(3);
    chk("single_last_hi", 32'(level_out), 1);
    idle(1);
    chk("single_gap_lo", 32'(level_out), 0);
    chk("single_gap_busy", 32'(busy), 1);
    idle(2);
    chk("single_idle", 32'(busy), 0);
    idle(2);
    chk("single_rises", 32'(rises), 1);
    chk("single_hi", 32'(hi_cyc), HC);

    // Pulses at t, t+2, t+3.
    rises = 0; hi_cyc = 0;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    idle(24);
`ifdef PULSE_STRETCHER_QUEUE_EN
    chk("three_rises", 32'(rises), 3);
    chk("three_ovf", 32'(overflow), 0);
`else
    chk("three_rises", 32'(rises), 1);
    chk("three_ovf", 32'(overflow), 1);
`endif
    cyc(1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 0);

    // Trigger plus five busy-time pulses: queue saturates.
    rises = 0; hi_cyc = 0;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
`ifdef PULSE_STRETCHER_QUEUE_EN
    chk("sat_pend", 32'(pending), PM);
`else
    chk("sat_pend", 32'(pending), 0);
`endif
    chk("sat_ovf", 32'(overflow), 1);
    idle(40);
`ifdef PULSE_STRETCHER_QUEUE_EN
    chk("sat_rises", 32'(rises), 4);
    chk("sat_hi", 32'(hi_cyc), 4 * HC);
`else
    chk("sat_rises", 32'(rises), 1);
    chk("sat_hi", 32'(hi_cyc), HC);
`endif
    cyc(1'b0, 1'b1);

    // Pulse exactly on the gap exit cycle restarts HIGH with no idle cycle.
    cyc(1'b1, 1'b0);
    idle(HC + GC - 1);
    chk("gx_busy_pre", 32'(busy), 1);
    cyc(1'b1, 1'b0);
    chk("gx_lvl", 32'(level_out), 1);
    chk("gx_pend", 32'(pending), 0);
    chk("gx_ovf", 32'(overflow), 0);
    idle(10);

    // Clear during HIGH with events queued.
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("clr_lvl", 32'(level_out), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_pend", 32'(pending), 0);
    chk("clr_ovf2", 32'(overflow), 0);
    // Clear beats a same-cycle pulse, which is silently discarded.
    cyc(1'b1, 1'b1);
    chk("clr_pulse_busy", 32'(busy), 0);
    chk("clr_pulse_ovf", 32'(overflow), 0);
    idle(2);

    // Asynchronous reset mid-HIGH.
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_lvl", 32'(level_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pend", 32'(pending), 0);
    m_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    prev_lvl = 1'b0;
    idle(2);
    cyc(1'b1, 1'b0);
    chk("arst_relat", 32'(level_out), 1);
    idle(10);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
    idle(30);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
